// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the HD44780 bus monitor.
package lcd_pkg;
    typedef enum logic [1:0] {INIT8, HI, LO} state_t;
    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CMD_HOME    = 8'h02;
    localparam logic [7:0] CMD_ENTRY   = 8'h04;
    localparam logic [7:0] CMD_DISPLAY = 8'h08;
    localparam logic [7:0] CMD_SHIFT   = 8'h10;
    localparam logic [7:0] CMD_CGRAM   = 8'h40;
    localparam logic [7:0] CMD_DDRAM   = 8'h80;
    localparam logic [6:0] LINE1_BASE  = 7'h00;
    localparam logic [6:0] LINE2_BASE  = 7'h40;
    localparam logic [6:0] LINE1_LAST  = 7'h27;
    localparam logic [6:0] LINE2_LAST  = 7'h67;
    localparam int         BUF_SIZE    = 32;
    localparam logic [7:0] BLANK       = 8'h20;

    // True when op is the highest set bit of v (op is a single-bit opcode mask).
    function automatic logic is_op(input logic [7:0] v, input logic [7:0] op);
        return (v & ~(op - 8'd1)) == op;
    endfunction

    function automatic logic [6:0] next_addr(input logic [6:0] a, input logic inc);
        return inc ? (a == LINE1_LAST ? LINE2_BASE : a == LINE2_LAST ? LINE1_BASE : a + 7'd1)
                   : (a == LINE1_BASE ? LINE2_LAST : a == LINE2_BASE ? LINE1_LAST : a - 7'd1);
    endfunction
endpackage

// File: rtl/lcd_strobe_sync.sv
// lcd_strobe_sync: synchronises the LCD bus and emits one write strobe per E falling edge.
// E-width checking is compiled in with LCD_TIMING_CHECK_EN.
module lcd_strobe_sync
    import lcd_pkg::*;
#(
    parameter int MIN_E_HIGH = 12
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       sf_e_i,
    input  logic       e_i,
    input  logic       rs_i,
    input  logic       rw_i,
    input  logic [3:0] nib_i,
    output logic       stb_o,
    output logic       rs_o,
    output logic [3:0] nib_o,
    output logic       timing_err_o
);
    logic [7:0] s1_q, s2_q;
    logic       e_prev_q, fall, width_ok;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q     <= '0;
            s2_q     <= '0;
            e_prev_q <= 1'b0;
        end else begin
            s1_q     <= {sf_e_i, e_i, rs_i, rw_i, nib_i};
            s2_q     <= s1_q;
            e_prev_q <= s2_q[6];
        end
    end

    // Reads (rw=1) never produce a strobe, so they cannot flag errors either.
    assign fall  = s2_q[7] && !s2_q[6] && e_prev_q && !s2_q[4];
    assign stb_o = fall && width_ok;
    assign rs_o  = s2_q[5];
    assign nib_o = s2_q[3:0];

`ifdef LCD_TIMING_CHECK_EN
    localparam int CW = $clog2(MIN_E_HIGH + 1);
    logic [CW-1:0] e_cnt_q;
    logic          terr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            e_cnt_q <= '0;
            terr_q  <= 1'b0;
        end else begin
            e_cnt_q <= !s2_q[6] ? '0 : (e_cnt_q == CW'(MIN_E_HIGH) ? e_cnt_q : e_cnt_q + 1'b1);
            terr_q  <= terr_q | (fall && !width_ok);
        end
    end

    assign width_ok     = e_cnt_q >= CW'(MIN_E_HIGH);
    assign timing_err_o = terr_q;
`else
    logic unused_min;
    assign unused_min   = MIN_E_HIGH > 0;
    assign width_ok     = 1'b1;
    assign timing_err_o = 1'b0;
`endif
endmodule

// File: rtl/lcd_bus_monitor.sv
// lcd_bus_monitor: slave-side HD44780 4-bit bus model with a 32-character display buffer.
// Define LCD_TIMING_CHECK_EN to enable the E-width check.
module lcd_bus_monitor
    import lcd_pkg::*;
#(
    parameter int BUSY_CYCLES = 2000,
    parameter int MIN_E_HIGH  = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sf_e,
    input  logic       e,
    input  logic       rs,
    input  logic       rw,
    input  logic       d,
    input  logic       c,
    input  logic       b,
    input  logic       a,
    input  logic [4:0] rd_idx,
    output logic [7:0] rd_char,
    output logic       byte_valid,
    output logic [7:0] byte_out,
    output logic       byte_rs,
    output logic       four_bit_mode,
    output logic       display_on,
    output logic       busy_err,
    output logic       timing_err
);
    localparam int           BW         = $clog2(4 * BUSY_CYCLES + 1);
    localparam logic [BW-1:0] BUSY_SHORT = BW'(BUSY_CYCLES);
    localparam logic [BW-1:0] BUSY_LONG  = BW'(4 * BUSY_CYCLES);

    state_t        state_q;
    logic [3:0]    hi_q, nib;
    logic [6:0]    addr_q;
    logic          inc_q, busy_err_q, four_q, disp_q, bv_q, brs_q;
    logic [BW-1:0] busy_q, busy_d;
    logic [7:0]    byte_q, full;
    logic [7:0]    mem_q [BUF_SIZE];
    logic          stb, srs, byte_done, is_cmd, is_data, wr_en;
    logic          cmd_clr, cmd_home, cmd_entry, cmd_disp, cmd_ddram;
    logic [4:0]    wr_idx;

    lcd_strobe_sync #(.MIN_E_HIGH(MIN_E_HIGH)) u_sync (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .sf_e_i      (sf_e),
        .e_i         (e),
        .rs_i        (rs),
        .rw_i        (rw),
        .nib_i       ({d, c, b, a}),
        .stb_o       (stb),
        .rs_o        (srs),
        .nib_o       (nib),
        .timing_err_o(timing_err)
    );

    assign full      = {hi_q, nib};
    assign byte_done = stb && state_q == LO;
    assign is_cmd    = byte_done && !srs;
    assign is_data   = byte_done && srs;
    assign cmd_clr   = is_cmd && is_op(full, CMD_CLEAR);
    assign cmd_home  = is_cmd && is_op(full, CMD_HOME);
    assign cmd_entry = is_cmd && is_op(full, CMD_ENTRY);
    assign cmd_disp  = is_cmd && is_op(full, CMD_DISPLAY);
    assign cmd_ddram = is_cmd && is_op(full, CMD_DDRAM);
    // 0x00-0x0F and 0x40-0x4F are the only visible DDRAM cells; bit 6 picks the line.
    assign wr_idx    = {addr_q[6], addr_q[3:0]};
    assign wr_en     = is_data && addr_q[5:4] == 2'b00;
    assign busy_d    = byte_done ? ((cmd_clr || cmd_home) ? BUSY_LONG : BUSY_SHORT)
                                 : (busy_q != '0 ? busy_q - 1'b1 : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT8;
            hi_q       <= '0;
            addr_q     <= '0;
            inc_q      <= 1'b1;
            busy_q     <= '0;
            busy_err_q <= 1'b0;
            four_q     <= 1'b0;
            disp_q     <= 1'b0;
            bv_q       <= 1'b0;
            byte_q     <= '0;
            brs_q      <= 1'b0;
            for (int i = 0; i < BUF_SIZE; i++) mem_q[i] <= BLANK;
        end else begin
            bv_q       <= byte_done;
            busy_q     <= busy_d;
            busy_err_q <= busy_err_q | (stb && busy_q != '0);
            if (stb) begin
                unique case (state_q)
                    INIT8: if (nib == 4'h2) begin
                        state_q <= HI;
                        four_q  <= 1'b1;
                    end
                    HI: begin
                        hi_q    <= nib;
                        state_q <= LO;
                    end
                    default: state_q <= HI;
                endcase
            end
            if (byte_done) begin
                byte_q <= full;
                brs_q  <= srs;
            end
            if (cmd_clr) begin
                for (int i = 0; i < BUF_SIZE; i++) mem_q[i] <= BLANK;
                addr_q <= '0;
                inc_q  <= 1'b1;
            end else if (cmd_home) addr_q <= '0;
            else if (cmd_entry) inc_q <= full[1];
            else if (cmd_disp) disp_q <= full[2];
            else if (cmd_ddram) addr_q <= full[6:0];
            else if (is_data) begin
                if (wr_en) mem_q[wr_idx] <= full;
                addr_q <= next_addr(addr_q, inc_q);
            end
        end
    end

    assign rd_char       = mem_q[rd_idx];
    assign byte_valid    = bv_q;
    assign byte_out      = byte_q;
    assign byte_rs       = brs_q;
    assign four_bit_mode = four_q;
    assign display_on    = disp_q;
    assign busy_err      = busy_err_q;
endmodule
